mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-master, one-slave AXI4-Lite arbiter. It shares the single memory port between the fetch unit
//  (IFU, read-only) and the load/store unit (LSU, read+write).
//  Sits between the pipeline's IFU/LSU and the memory/SRAM slave. One outstanding transaction total.
//  The grant is registered; the grant holder's channels are routed to the slave combinationally.
// PARAMETERS
//  ADDR_W  32  address width, all address channels
//  DATA_W  32  data width; strobe width is DATA_W/8
// PORTS
//  clk                                   in   1       clock; all logic on posedge
//  rst                                   in   1       synchronous, active-high reset
//  ifu_araddr, ifu_arvalid               in   32,1    IFU read address request
//  ifu_arready                           out  1       IFU AR accept
//  ifu_rdata, ifu_rresp, ifu_rvalid      out  32,2,1  IFU read response
//  ifu_rready                            in   1       IFU R accept
//  lsu_araddr, lsu_arvalid               in   32,1    LSU read address request
//  lsu_arready                           out  1       LSU AR accept
//  lsu_rdata, lsu_rresp, lsu_rvalid      out  32,2,1  LSU read response
//  lsu_rready                            in   1       LSU R accept
//  lsu_awaddr, lsu_awvalid               in   32,1    LSU write address
//  lsu_wdata, lsu_wstrb, lsu_wvalid      in   32,4,1  LSU write data
//  lsu_awready, lsu_wready               out  1,1     LSU AW/W accept
//  lsu_bresp, lsu_bvalid                 out  2,1     LSU write response
//  lsu_bready                            in   1       LSU B accept
//  m_araddr, m_arvalid / m_arready       out/in       slave AR channel
//  m_rdata, m_rresp, m_rvalid / m_rready in/out       slave R channel
//  m_awaddr, m_awvalid / m_awready       out/in       slave AW channel
//  m_wdata, m_wstrb, m_wvalid / m_wready out/in       slave W channel
//  m_bresp, m_bvalid / m_bready          in/out       slave B channel
// BEHAVIOUR
//  - States: IDLE, IF_RD, LS_RD, LS_WR. On reset: IDLE, aw_done=w_done=0, every valid/ready output 0.
//    Under ARB_RR_EN, last_lsu also resets to 0.
//  - IDLE: no forwarding; every output valid/ready is 0.
//    Requests: IFU = ifu_arvalid; LSU read = lsu_arvalid; LSU write = lsu_awvalid | lsu_wvalid.
//    The winner is registered, and the grant state is entered next cycle. Arbitration latency is 1 cycle.
//  - Priority: LSU write > LSU read > IFU (fixed). Both LSU requests asserted together: write is served first.
//  - Grant state: the holder's request and response channels are wired to m_*. Non-holders see ready=0, resp valid=0.
//    m_* request outputs for unused channels are 0.
//  - IF_RD/LS_RD: m_arvalid = src arvalid & ~ar_done; ar_done is set on the AR handshake.
//    R handshake (m_rvalid & src rready) -> IDLE. ar_done is cleared.
//  - LS_WR: AW and W are independent. Each valid is masked once its own handshake completes (aw_done, w_done).
//    m_bready = lsu_bready only after aw_done & w_done. B handshake -> IDLE; both flags are cleared.
//  - Response data and resp (incl. SLVERR/DECERR) pass through unmodified.
//  - Addresses and data are not latched. Masters hold them stable until their handshake, per AXI rules.
//  - Minimum transaction: IDLE + 1 address cycle + 1 response cycle. Back-to-back transactions always pass through IDLE.
//  - rst asserted mid-transaction: IDLE on the next edge, all flags cleared, in-flight transfer dropped.
//    The slave must share the same reset.
// CONFIGURATION
//  ARB_RR_EN defined: IFU vs LSU ties resolve by a round-robin register last_lsu.
//    last_lsu=1 after an LSU grant, 0 after an IFU grant.
//    On a tie: last_lsu=1 -> IFU wins; last_lsu=0 -> LSU wins. LSU write > LSU read still holds.
//  ARB_RR_EN undefined: fixed priority as above; no last_lsu register.
// STRUCTURE
//  Package mem_arb_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_IF_RD, ARB_LS_RD, ARB_LS_WR} arb_state_t;
//    plus constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
//  Sub-module mem_arb_pick (combinational): request vector + last_lsu -> next arb_state_t.
//    The FSM, done flags and channel muxes stay in mem_arbiter.
// TESTING
//  1 Reset: rst=1 for 3 cycles with all requests high.
//    -> state IDLE, all out valids/readies 0; after release the LSU write is granted 1 cycle later.
//  2 IFU read alone: ifu_araddr=0x8000_0000; slave arready at cycle 2; slave rvalid rdata=0x0000_0413.
//    -> IFU gets rdata/rresp=0; lsu_rvalid stays 0; IDLE after R handshake.
//  3 Tie: IFU read 0x8000_0004 + LSU read 0x8000_1000 held together for two rounds.
//    -> fixed: LSU served, then IFU.
//    -> ARB_RR_EN: LSU then IFU, and the next tie goes to LSU.
//  4 LSU write 0x8000_2000, wdata=0xDEAD_BEEF, wstrb=4'b0011; m_awready in cycle n, m_wready in cycle n+2.
//    -> m_awvalid drops after n; m_wvalid stays high until n+2.
//    -> bresp=2'b10 forwarded to lsu_bresp; then IDLE.
//  5 rst=1 in LS_WR after AW only (before W/B).
//    -> next cycle IDLE, aw_done=0, all outputs 0; a new IFU read is then granted normally.
//  6 Backpressure: ifu_rready=0 for 3 cycles while m_rvalid=1.
//    -> m_rready=0, state stays IF_RD; completes when ifu_rready=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master AXI4-Lite memory arbiter.
// Used by mem_arb_pick and mem_arbiter; the optional ARB_RR_EN build
// uses is_lsu_grant to track which side was served last.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IF_RD = 2'd1,
    ARB_LS_RD = 2'd2,
    ARB_LS_WR = 2'd3
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // True when a grant belongs to the load/store unit (read or write).
  function automatic logic is_lsu_grant(input arb_state_t s);
    return (s == ARB_LS_RD) || (s == ARB_LS_WR);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for mem_arbiter.
// Default: fixed priority LSU write > LSU read > IFU.
// ARB_RR_EN: an IFU-vs-LSU tie goes to the IFU if the LSU was served last,
// otherwise to the LSU; among LSU requests the write still wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req_ifu,
  input  logic       i_req_lsu_rd,
  input  logic       i_req_lsu_wr,
`ifdef ARB_RR_EN
  input  logic       i_last_lsu,
`endif
  output arb_state_t o_grant
);

  // Pick the next grant state from the current request set.
  always_comb begin
    o_grant = ARB_IDLE;
`ifdef ARB_RR_EN
    if (i_req_ifu && (i_req_lsu_rd || i_req_lsu_wr) && i_last_lsu) begin
      o_grant = ARB_IF_RD;
    end else if (i_req_lsu_wr) begin
      o_grant = ARB_LS_WR;
    end else if (i_req_lsu_rd) begin
      o_grant = ARB_LS_RD;
    end else if (i_req_ifu) begin
      o_grant = ARB_IF_RD;
    end
`else
    if (i_req_lsu_wr) begin
      o_grant = ARB_LS_WR;
    end else if (i_req_lsu_rd) begin
      o_grant = ARB_LS_RD;
    end else if (i_req_ifu) begin
      o_grant = ARB_IF_RD;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// One outstanding transaction; the grant is registered and the holder's
// channels are routed to the slave combinationally. Every transaction
// returns through IDLE before the next grant.
// Optional macro ARB_RR_EN: round-robin IFU/LSU tie-break via r_last_lsu.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read port
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  // LSU read port
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  // LSU write port
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_awready,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  // Slave port
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  arb_state_t w_pick;

  logic r_ar_done;
  logic r_aw_done;
  logic r_w_done;

  logic w_req_ifu;
  logic w_req_lsu_rd;
  logic w_req_lsu_wr;

  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;

  assign w_req_ifu    = ifu_arvalid;
  assign w_req_lsu_rd = lsu_arvalid;
  assign w_req_lsu_wr = lsu_awvalid | lsu_wvalid;

  // Slave-side handshakes; the muxes below already mask non-holders.
  assign w_ar_hs = m_arvalid & m_arready;
  assign w_r_hs  = m_rvalid  & m_rready;
  assign w_aw_hs = m_awvalid & m_awready;
  assign w_w_hs  = m_wvalid  & m_wready;
  assign w_b_hs  = m_bvalid  & m_bready;

`ifdef ARB_RR_EN
  logic r_last_lsu;

  mem_arb_pick u_pick (
    .i_req_ifu    (w_req_ifu),
    .i_req_lsu_rd (w_req_lsu_rd),
    .i_req_lsu_wr (w_req_lsu_wr),
    .i_last_lsu   (r_last_lsu),
    .o_grant      (w_pick)
  );

  // Remember which side won the most recent grant for tie-breaking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_lsu <= 1'b0;
    end else if ((r_state == ARB_IDLE) && (w_pick != ARB_IDLE)) begin
      r_last_lsu <= is_lsu_grant(w_pick);
    end
  end
`else
  mem_arb_pick u_pick (
    .i_req_ifu    (w_req_ifu),
    .i_req_lsu_rd (w_req_lsu_rd),
    .i_req_lsu_wr (w_req_lsu_wr),
    .o_grant      (w_pick)
  );
`endif

  // Grant state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Per-channel completion flags so each address/data valid is offered once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ARB_IF_RD, ARB_LS_RD: begin
          if (w_r_hs) begin
            r_ar_done <= 1'b0;
          end else if (w_ar_hs) begin
            r_ar_done <= 1'b1;
          end
        end
        ARB_LS_WR: begin
          if (w_b_hs) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        default: begin
          r_ar_done <= 1'b0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
      endcase
    end
  end

  // Next grant: arbitrate from IDLE, return to IDLE on the final response handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:             w_next_state = w_pick;
      ARB_IF_RD, ARB_LS_RD: if (w_r_hs) w_next_state = ARB_IDLE;
      ARB_LS_WR:            if (w_b_hs) w_next_state = ARB_IDLE;
      default:              w_next_state = ARB_IDLE;
    endcase
  end

  // Route the grant holder to the slave; everything else stays quiet.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = RESP_OKAY;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = RESP_OKAY;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = RESP_OKAY;
    lsu_bvalid  = 1'b0;
    m_araddr    = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awaddr    = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    case (r_state)
      ARB_IF_RD: begin
        m_araddr    = ifu_araddr;
        m_arvalid   = ifu_arvalid & ~r_ar_done;
        ifu_arready = m_arready & ~r_ar_done;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rvalid  = m_rvalid;
        m_rready    = ifu_rready;
      end
      ARB_LS_RD: begin
        m_araddr    = lsu_araddr;
        m_arvalid   = lsu_arvalid & ~r_ar_done;
        lsu_arready = m_arready & ~r_ar_done;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rvalid  = m_rvalid;
        m_rready    = lsu_rready;
      end
      ARB_LS_WR: begin
        m_awaddr    = lsu_awaddr;
        m_awvalid   = lsu_awvalid & ~r_aw_done;
        lsu_awready = m_awready & ~r_aw_done;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wvalid    = lsu_wvalid & ~r_w_done;
        lsu_wready  = m_wready & ~r_w_done;
        lsu_bresp   = m_bresp;
        lsu_bvalid  = m_bvalid & r_aw_done & r_w_done;
        m_bready    = lsu_bready & r_aw_done & r_w_done;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected
// slave-side requests and master-side responses into queues; a negedge
// monitor pops and compares whenever a handshake is presented.
// Honours ARB_RR_EN for the arbitration order of the reset scenario.
module tb_mem_arbiter;

  localparam int SRC_IFU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_B   = 2;

  typedef struct {
    int          src;
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic clk, rst;
  logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata;
  logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic [1:0] ifu_rresp, lsu_rresp, lsu_bresp;
  logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic lsu_awvalid, lsu_wvalid, lsu_awready, lsu_wready, lsu_bvalid, lsu_bready;
  logic [3:0] lsu_wstrb, m_wstrb;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0] m_rresp, m_bresp;

  int checks = 0;
  int errors = 0;

  logic [31:0] arQ[$];
  logic [31:0] awQ[$];
  wr_t         wQ[$];
  rsp_t        rspQ[$];

  int arDelay = 0, awDelay = 0, wDelay = 0;
  logic [1:0] slvRresp = 2'b00, slvBresp = 2'b00;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_awready(lsu_awready), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failEvent(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got unexpected or missing event, expected a matching event", name);
  endtask

  task automatic popRsp(input int src, input logic [31:0] data, input logic [1:0] resp);
    rsp_t e;
    if (rspQ.size() == 0) begin
      failEvent("rsp_unexpected");
    end else begin
      e = rspQ.pop_front();
      checkOutput("rsp_src", src, e.src);
      checkOutput("rsp_data", data, e.data);
      checkOutput("rsp_resp", {30'b0, resp}, {30'b0, e.resp});
    end
  endtask

  // Monitor: every handshake that will complete at the next edge is scored.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_arvalid && m_arready) begin
        if (arQ.size() == 0) failEvent("ar_unexpected");
        else checkOutput("m_araddr", m_araddr, arQ.pop_front());
      end
      if (m_awvalid && m_awready) begin
        if (awQ.size() == 0) failEvent("aw_unexpected");
        else checkOutput("m_awaddr", m_awaddr, awQ.pop_front());
      end
      if (m_wvalid && m_wready) begin
        if (wQ.size() == 0) begin
          failEvent("w_unexpected");
        end else begin
          wr_t w;
          w = wQ.pop_front();
          checkOutput("m_wdata", m_wdata, w.data);
          checkOutput("m_wstrb", {28'b0, m_wstrb}, {28'b0, w.strb});
        end
      end
      if (ifu_rvalid && ifu_rready) popRsp(SRC_IFU, ifu_rdata, ifu_rresp);
      if (lsu_rvalid && lsu_rready) popRsp(SRC_LSU, lsu_rdata, lsu_rresp);
      if (lsu_bvalid && lsu_bready) popRsp(SRC_B, 32'h0, lsu_bresp);
    end
  end

  function automatic logic [31:0] slaveData(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Slave model with programmable ready delays, sharing the arbiter reset.
  initial begin
    logic sRst, sAr, sR, sAw, sW, sB;
    logic [31:0] sArAddr;
    int arWait, awWait, wWait;
    logic awGot, wGot;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
    arWait = 0; awWait = 0; wWait = 0; awGot = 0; wGot = 0;
    forever begin
      @(negedge clk);
      sRst = rst;
      sAr = m_arvalid & m_arready; sArAddr = m_araddr;
      sR = m_rvalid & m_rready;
      sAw = m_awvalid & m_awready;
      sW = m_wvalid & m_wready;
      sB = m_bvalid & m_bready;
      @(posedge clk);
      #2;
      if (sRst) begin
        m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        arWait = 0; awWait = 0; wWait = 0; awGot = 0; wGot = 0;
      end else begin
        if (sR) m_rvalid = 0;
        if (sAr) begin
          m_arready = 0; arWait = 0;
          m_rvalid = 1; m_rdata = slaveData(sArAddr); m_rresp = slvRresp;
        end else if (m_arvalid && !m_arready && !m_rvalid) begin
          if (arWait >= arDelay) m_arready = 1;
          else arWait++;
        end
        if (sB) begin
          m_bvalid = 0; awGot = 0; wGot = 0;
        end
        if (sAw) begin
          m_awready = 0; awGot = 1; awWait = 0;
        end else if (m_awvalid && !m_awready && !awGot) begin
          if (awWait >= awDelay) m_awready = 1;
          else awWait++;
        end
        if (sW) begin
          m_wready = 0; wGot = 1; wWait = 0;
        end else if (m_wvalid && !m_wready && !wGot) begin
          if (wWait >= wDelay) m_wready = 1;
          else wWait++;
        end
        if (awGot && wGot && !m_bvalid && !sB) begin
          m_bvalid = 1; m_bresp = slvBresp;
        end
      end
    end
  end

  task automatic pushRead(input int src, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp);
    rsp_t e;
    arQ.push_back(addr);
    e.src = src; e.data = data; e.resp = resp;
    rspQ.push_back(e);
  endtask

  task automatic pushWrite(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] bresp);
    wr_t w;
    rsp_t e;
    awQ.push_back(addr);
    w.data = data; w.strb = strb;
    wQ.push_back(w);
    e.src = SRC_B; e.data = 32'h0; e.resp = bresp;
    rspQ.push_back(e);
  endtask

  // One clock of master behaviour: drop each valid after its handshake.
  task automatic applyStimulus();
    logic a, b, c, d;
    @(negedge clk);
    a = ifu_arvalid & ifu_arready;
    b = lsu_arvalid & lsu_arready;
    c = lsu_awvalid & lsu_awready;
    d = lsu_wvalid & lsu_wready;
    @(posedge clk);
    #1;
    if (a) ifu_arvalid = 0;
    if (b) lsu_arvalid = 0;
    if (c) lsu_awvalid = 0;
    if (d) lsu_wvalid = 0;
  endtask

  task automatic waitQuiet(input string name, input int maxCycles);
    int n = 0;
    while ((ifu_arvalid || lsu_arvalid || lsu_awvalid || lsu_wvalid || rspQ.size() != 0)
           && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    if (n >= maxCycles) failEvent({name, "_timeout"});
    #2;
  endtask

  task automatic checkIdle(input string name);
    checkOutput(name, {20'b0, ifu_arready, lsu_arready, lsu_awready, lsu_wready, ifu_rvalid,
                       lsu_rvalid, lsu_bvalid, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready},
                32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic seen;
    rst = 1;
    ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 1;
    lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 1;
    lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0;
    lsu_bready = 1;

    // Reset with every request asserted.
    ifu_araddr = 32'h8000_0008; ifu_arvalid = 1;
    lsu_araddr = 32'h8000_100C; lsu_arvalid = 1;
    lsu_awaddr = 32'h8000_3000; lsu_awvalid = 1;
    lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF; lsu_wvalid = 1;
    pushWrite(32'h8000_3000, 32'h1234_5678, 4'hF, 2'b00);
`ifdef ARB_RR_EN
    pushRead(SRC_IFU, 32'h8000_0008, 32'h25A5_5A52, 2'b00);
    pushRead(SRC_LSU, 32'h8000_100C, 32'h25A5_4A56, 2'b00);
`else
    pushRead(SRC_LSU, 32'h8000_100C, 32'h25A5_4A56, 2'b00);
    pushRead(SRC_IFU, 32'h8000_0008, 32'h25A5_5A52, 2'b00);
`endif
    repeat (3) begin
      @(posedge clk);
      #3;
      checkIdle("reset_idle");
    end
    rst = 0;
    @(posedge clk);
    #3;
    checkOutput("grant_after_reset_awvalid", {31'b0, m_awvalid}, 32'h1);
    checkOutput("grant_after_reset_arvalid", {31'b0, m_arvalid}, 32'h0);
    waitQuiet("t1", 60);
    checkIdle("t1_idle");

    // IFU read alone, slave AR accepted one cycle late.
    arDelay = 1;
    ifu_araddr = 32'h8000_0000;
    pushRead(SRC_IFU, 32'h8000_0000, 32'h0000_0413, 2'b00);
    ifu_arvalid = 1;
    n = 0; seen = 0;
    while ((ifu_arvalid || rspQ.size() != 0) && n < 20) begin
      applyStimulus();
      #2;
      if (ifu_rvalid && !seen) begin
        seen = 1;
        checkOutput("t2_lsu_rvalid", {31'b0, lsu_rvalid}, 32'h0);
      end
      n++;
    end
    if (n >= 20) failEvent("t2_timeout");
    checkIdle("t2_idle");
    arDelay = 0;

    // IFU/LSU read tie, two rounds: LSU then IFU each round.
    for (int r = 0; r < 2; r++) begin
      ifu_araddr = 32'h8000_0004;
      lsu_araddr = 32'h8000_1000;
      pushRead(SRC_LSU, 32'h8000_1000, 32'h25A5_4A5A, 2'b00);
      pushRead(SRC_IFU, 32'h8000_0004, 32'h25A5_5A5E, 2'b00);
      ifu_arvalid = 1;
      lsu_arvalid = 1;
      waitQuiet("t3", 40);
      checkIdle("t3_idle");
    end

    // LSU write with W accepted two cycles after AW and an SLVERR response.
    wDelay = 2;
    slvBresp = 2'b10;
    lsu_awaddr = 32'h8000_2000; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011;
    pushWrite(32'h8000_2000, 32'hDEAD_BEEF, 4'b0011, 2'b10);
    lsu_awvalid = 1; lsu_wvalid = 1;
    applyStimulus(); #2;
    checkOutput("t4_awvalid_n", {31'b0, m_awvalid}, 32'h1);
    checkOutput("t4_wvalid_n", {31'b0, m_wvalid}, 32'h1);
    applyStimulus(); #2;
    checkOutput("t4_awvalid_n1", {31'b0, m_awvalid}, 32'h0);
    checkOutput("t4_wvalid_n1", {31'b0, m_wvalid}, 32'h1);
    applyStimulus(); #2;
    checkOutput("t4_wvalid_n2", {31'b0, m_wvalid}, 32'h1);
    applyStimulus(); #2;
    checkOutput("t4_wvalid_n3", {31'b0, m_wvalid}, 32'h0);
    waitQuiet("t4", 20);
    checkIdle("t4_idle");
    slvBresp = 2'b00;

    // Reset in the middle of a write, after AW only.
    wDelay = 6;
    lsu_awaddr = 32'h8000_4000; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'hF;
    awQ.push_back(32'h8000_4000);
    lsu_awvalid = 1; lsu_wvalid = 1;
    applyStimulus();
    applyStimulus();
    rst = 1;
    lsu_awvalid = 0; lsu_wvalid = 0;
    @(posedge clk);
    #3;
    checkIdle("t5_reset_idle");
    rst = 0;
    wDelay = 0;
    ifu_araddr = 32'h8000_0010;
    pushRead(SRC_IFU, 32'h8000_0010, 32'h25A5_5A4A, 2'b00);
    ifu_arvalid = 1;
    waitQuiet("t5_read", 20);
    checkIdle("t5_read_idle");
    pushWrite(32'h8000_4000, 32'hCAFE_F00D, 4'hF, 2'b00);
    lsu_awvalid = 1; lsu_wvalid = 1;
    applyStimulus(); #2;
    checkOutput("t5_awvalid_after_reset", {31'b0, m_awvalid}, 32'h1);
    waitQuiet("t5_write", 20);
    checkIdle("t5_write_idle");

    // IFU response backpressure.
    ifu_rready = 0;
    ifu_araddr = 32'h8000_0020;
    pushRead(SRC_IFU, 32'h8000_0020, 32'h25A5_5A7A, 2'b00);
    ifu_arvalid = 1;
    n = 0;
    while (!m_rvalid && n < 20) begin
      applyStimulus();
      #2;
      n++;
    end
    if (n >= 20) failEvent("t6_rvalid_timeout");
    repeat (3) begin
      checkOutput("t6_m_rready", {31'b0, m_rready}, 32'h0);
      checkOutput("t6_ifu_rvalid", {31'b0, ifu_rvalid}, 32'h1);
      applyStimulus();
      #2;
    end
    ifu_rready = 1;
    waitQuiet("t6", 20);
    checkIdle("t6_idle");

    checkOutput("queues_empty", arQ.size() + awQ.size() + wQ.size() + rspQ.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
